// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: time-of-week keeper with NA alarms sharing one ringer.
// Ringer supports snooze, dismiss and automatic timeout.
module multi_alarm_clock #(
    parameter  int NS       = 60,
    parameter  int NH       = 24,
    parameter  int ND       = 7,
    parameter  int NA       = 4,
    parameter  int SNZ      = 300,
    parameter  int RING_MAX = 60,
    localparam int AW       = (NA > 1) ? $clog2(NA) : 1
) (
    input  logic          Pulse,
    input  logic          Reset,
    input  logic          Timeset,
    input  logic          Alarmset,
    input  logic          Minadv,
    input  logic          Hrsadv,
    input  logic          Dayadv,
    input  logic [AW-1:0] AlarmSel,
    input  logic [NA-1:0] AlarmEn,
    input  logic          Snooze,
    input  logic          Stop,
    output logic [6:0]    TSec,
    output logic [6:0]    TMin,
    output logic [6:0]    THrs,
    output logic [2:0]    TDay,
    output logic [6:0]    DispMin,
    output logic [6:0]    DispHrs,
    output logic          Buzz,
    output logic [AW-1:0] BuzzIdx,
    output logic          Snoozing
);

    localparam int SW = $clog2(NS);
    localparam int HW = $clog2(NH);
    localparam int DW = $clog2(ND);
    localparam int RW = $clog2(RING_MAX);
    localparam int ZW = $clog2(SNZ);

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZE
    } state_t;

    logic [SW-1:0] sec_q, min_q;
    logic [HW-1:0] hrs_q;
    logic [DW-1:0] day_q;
    logic [SW-1:0] al_min [NA];
    logic [HW-1:0] al_hrs [NA];

    state_t        state_q, state_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [ZW-1:0] snz_q, snz_d;
    logic [AW-1:0] idx_q, idx_d;

    logic          sec_wrap, min_wrap, hrs_wrap, day_wrap;
    logic [SW-1:0] sec_nx, min_nx;
    logic [HW-1:0] hrs_nx;
    logic [DW-1:0] day_nx;
    logic [SW-1:0] sel_min, sel_min_nx;
    logic [HW-1:0] sel_hrs, sel_hrs_nx;
    logic          match;
    logic [AW-1:0] match_idx;
    logic          armed;

    assign sec_wrap = (sec_q == SW'(NS - 1));
    assign min_wrap = (min_q == SW'(NS - 1));
    assign hrs_wrap = (hrs_q == HW'(NH - 1));
    assign day_wrap = (day_q == DW'(ND - 1));
    assign sec_nx   = sec_wrap ? '0 : sec_q + SW'(1);
    assign min_nx   = min_wrap ? '0 : min_q + SW'(1);
    assign hrs_nx   = hrs_wrap ? '0 : hrs_q + HW'(1);
    assign day_nx   = day_wrap ? '0 : day_q + DW'(1);

    assign sel_min    = al_min[AlarmSel];
    assign sel_hrs    = al_hrs[AlarmSel];
    assign sel_min_nx = (sel_min == SW'(NS - 1)) ? '0 : sel_min + SW'(1);
    assign sel_hrs_nx = (sel_hrs == HW'(NH - 1)) ? '0 : sel_hrs + HW'(1);

    // Run the time chain with carries, or step fields independently in set mode
    always_ff @(posedge Pulse) begin
        if (!Reset) begin
            sec_q <= '0;
            min_q <= '0;
            hrs_q <= '0;
            day_q <= '0;
        end else if (!Timeset) begin
            sec_q <= sec_nx;
            if (sec_wrap) begin
                min_q <= min_nx;
                if (min_wrap) begin
                    hrs_q <= hrs_nx;
                    if (hrs_wrap) day_q <= day_nx;
                end
            end
        end else begin
            if (Minadv) min_q <= min_nx;
            if (Hrsadv) hrs_q <= hrs_nx;
            if (Dayadv) day_q <= day_nx;
        end
    end

    // Edit the selected alarm; Timeset takes precedence over Alarmset
    always_ff @(posedge Pulse) begin
        if (!Reset) begin
            for (int k = 0; k < NA; k++) begin
                al_min[k] <= '0;
                al_hrs[k] <= '0;
            end
        end else if (Alarmset && !Timeset) begin
            if (Minadv) al_min[AlarmSel] <= sel_min_nx;
            if (Hrsadv) al_hrs[AlarmSel] <= sel_hrs_nx;
        end
    end

    // Lowest-index armed alarm equal to the current minute at second zero
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        if (state_q == IDLE && !Timeset && sec_q == '0) begin
            for (int k = NA - 1; k >= 0; k--) begin
                if (AlarmEn[k] && al_hrs[k] == hrs_q && al_min[k] == min_q) begin
                    match     = 1'b1;
                    match_idx = AW'(k);
                end
            end
        end
    end

    assign armed = AlarmEn[idx_q];

    // Ringer next-state: dismiss, snooze, timeout and re-ring
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (match) begin
                    state_d = RINGING;
                    ring_d  = '0;
                    idx_d   = match_idx;
                end
            end
            RINGING: begin
                if (Stop || !armed) begin
                    state_d = IDLE;
                end else if (Snooze) begin
                    state_d = SNOOZE;
                    snz_d   = ZW'(SNZ - 1);
                end else if (ring_q == RW'(RING_MAX - 1)) begin
                    state_d = IDLE;
                end else begin
                    ring_d = ring_q + RW'(1);
                end
            end
            SNOOZE: begin
                if (Stop || !armed) begin
                    state_d = IDLE;
                end else if (snz_q == '0) begin
                    state_d = RINGING;
                    ring_d  = '0;
                end else begin
                    snz_d = snz_q - ZW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ringer state register
    always_ff @(posedge Pulse) begin
        if (!Reset) begin
            state_q <= IDLE;
            ring_q  <= '0;
            snz_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
            idx_q   <= idx_d;
        end
    end

    assign TSec     = 7'(sec_q);
    assign TMin     = 7'(min_q);
    assign THrs     = 7'(hrs_q);
    assign TDay     = 3'(day_q);
    assign DispMin  = Alarmset ? 7'(sel_min) : TMin;
    assign DispHrs  = Alarmset ? 7'(sel_hrs) : THrs;
    assign Buzz     = (state_q == RINGING);
    assign Snoozing = (state_q == SNOOZE);
    assign BuzzIdx  = idx_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock: directed and random checks against a
// seconds-of-week reference model with a countdown ringer model.
module tb_multi_alarm_clock;

    localparam int NA       = 4;
    localparam int SNZ      = 300;
    localparam int RING_MAX = 60;
    localparam int WEEK     = 7 * 24 * 3600;

    logic       Pulse = 1'b0;
    logic       Reset, Timeset, Alarmset;
    logic       Minadv, Hrsadv, Dayadv;
    logic [1:0] AlarmSel;
    logic [3:0] AlarmEn;
    logic       Snooze, Stop;
    logic [6:0] TSec, TMin, THrs, DispMin, DispHrs;
    logic [2:0] TDay;
    logic       Buzz, Snoozing;
    logic [1:0] BuzzIdx;

    multi_alarm_clock dut (
        .Pulse(Pulse), .Reset(Reset), .Timeset(Timeset),
        .Alarmset(Alarmset), .Minadv(Minadv), .Hrsadv(Hrsadv),
        .Dayadv(Dayadv), .AlarmSel(AlarmSel), .AlarmEn(AlarmEn),
        .Snooze(Snooze), .Stop(Stop), .TSec(TSec), .TMin(TMin),
        .THrs(THrs), .TDay(TDay), .DispMin(DispMin),
        .DispHrs(DispHrs), .Buzz(Buzz), .BuzzIdx(BuzzIdx),
        .Snoozing(Snoozing)
    );

    always #5 Pulse = ~Pulse;

    // model: t = seconds since day0 00:00:00; mode 0 quiet, 1 ringing, 2 snoozing
    int t;
    int al_h [NA];
    int al_m [NA];
    int mode, ring_left, snz_left, idx;
    int checks = 0;
    int fails  = 0;

    logic [42:0] obs;
    assign obs = {TSec, TMin, THrs, TDay, DispMin, DispHrs,
                  Buzz, BuzzIdx, Snoozing};

    task automatic model_edge();
        int s, m, h, d, k;
        if (!Reset) begin
            t = 0;
            for (int j = 0; j < NA; j++) begin
                al_h[j] = 0;
                al_m[j] = 0;
            end
            mode = 0; ring_left = 0; snz_left = 0; idx = 0;
            return;
        end
        s = t % 60;
        m = (t / 60) % 60;
        h = (t / 3600) % 24;
        d = t / 86400;
        k = -1;
        if (mode == 0 && !Timeset && s == 0)
            for (int j = NA - 1; j >= 0; j--)
                if (AlarmEn[j] && al_h[j] == h && al_m[j] == m) k = j;
        case (mode)
            0: if (k >= 0) begin
                mode = 1; ring_left = RING_MAX; idx = k;
            end
            1: if (Stop || !AlarmEn[idx]) mode = 0;
               else if (Snooze) begin mode = 2; snz_left = SNZ; end
               else begin
                   ring_left--;
                   if (ring_left == 0) mode = 0;
               end
            default: if (Stop || !AlarmEn[idx]) mode = 0;
               else begin
                   snz_left--;
                   if (snz_left == 0) begin mode = 1; ring_left = RING_MAX; end
               end
        endcase
        if (!Timeset) t = (t + 1) % WEEK;
        else begin
            if (Minadv) m = (m + 1) % 60;
            if (Hrsadv) h = (h + 1) % 24;
            if (Dayadv) d = (d + 1) % 7;
            t = ((d * 24 + h) * 60 + m) * 60 + s;
        end
        if (Alarmset && !Timeset) begin
            if (Minadv) al_m[AlarmSel] = (al_m[AlarmSel] + 1) % 60;
            if (Hrsadv) al_h[AlarmSel] = (al_h[AlarmSel] + 1) % 24;
        end
    endtask

    function automatic logic [42:0] exp_vec();
        int dm, dh;
        dm = Alarmset ? al_m[AlarmSel] : (t / 60) % 60;
        dh = Alarmset ? al_h[AlarmSel] : (t / 3600) % 24;
        return {7'(t % 60), 7'((t / 60) % 60), 7'((t / 3600) % 24),
                3'(t / 86400), 7'(dm), 7'(dh),
                mode == 1, 2'(idx), mode == 2};
    endfunction

    task automatic tick();
        @(posedge Pulse);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic ts, input logic as,
                         input logic mi, input logic hr, input logic dy);
        Timeset = ts; Alarmset = as;
        Minadv = mi; Hrsadv = hr; Dayadv = dy;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        AlarmSel = 0; AlarmEn = 0; Snooze = 0; Stop = 0;
        do_reset();
        checks++;
        if (obs !== 43'd0) begin
            fails++;
            $display("FAIL reset_state got=%h want=0", obs);
        end
        tick();
        checks++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL reset_run got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_rollover();
        do_reset();
        repeat (50) tick();
        for (int i = 0; i < 59; i++) begin
            drive(1, 0, 1, i < 23, i < 6);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL preload got=%h want=%h", obs, exp_vec());
            end
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({THrs, TMin, TSec, TDay} !== {7'd23, 7'd59, 7'd50, 3'd6}) begin
            fails++;
            $display("FAIL preload_val got=%0d:%0d:%0d d%0d want=23:59:50 d6",
                     THrs, TMin, TSec, TDay);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL rollover got=%h want=%h", obs, exp_vec());
            end
        end
        checks++;
        if ({THrs, TMin, TSec, TDay} !== 24'd0) begin
            fails++;
            $display("FAIL week_wrap got=%0d:%0d:%0d d%0d want=0:0:0 d0",
                     THrs, TMin, TSec, TDay);
        end
    endtask

    task automatic test_alarm_ring();
        int n;
        logic [1:0] first_idx;
        do_reset();
        for (int a = 1; a <= 2; a++) begin
            AlarmSel = 2'(a);
            for (int i = 0; i < 30; i++) begin
                drive(0, 1, 1, i < 7, 0);
                tick();
            end
        end
        for (int i = 0; i < 28; i++) begin
            drive(1, 0, 1, i < 7, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        AlarmEn = 4'b0110;
        for (int i = 0; i < 100 && !Buzz; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL ring_wait got=%h want=%h", obs, exp_vec());
            end
        end
        checks++;
        if (Buzz !== 1'b1 || {THrs, TMin, TSec} !== {7'd7, 7'd30, 7'd1}) begin
            fails++;
            $display("FAIL ring_start buzz=%b time=%0d:%0d:%0d want 1 07:30:01",
                     Buzz, THrs, TMin, TSec);
        end
        first_idx = BuzzIdx;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!Buzz) break;
            n++;
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL ringing got=%h want=%h", obs, exp_vec());
            end
        end
        checks++;
        if (n != RING_MAX || first_idx !== 2'd1) begin
            fails++;
            $display("FAIL ring_len cycles=%0d idx=%0d want %0d idx 1",
                     n, first_idx, RING_MAX);
        end
        AlarmEn = 0;
    endtask

    task automatic test_snooze();
        int n;
        do_reset();
        AlarmSel = 0;
        drive(0, 1, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        AlarmEn = 4'b0001;
        for (int i = 0; i < 100 && !Buzz; i++) tick();
        repeat (5) tick();
        Snooze = 1;
        tick();
        Snooze = 0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (!Snoozing) break;
            n++;
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL snoozing got=%h want=%h", obs, exp_vec());
            end
        end
        checks++;
        if (n != SNZ || Buzz !== 1'b1) begin
            fails++;
            $display("FAIL snooze_len cycles=%0d buzz=%b want %0d buzz 1",
                     n, Buzz, SNZ);
        end
        Stop = 1; Snooze = 1;
        tick();
        Stop = 0; Snooze = 0;
        checks++;
        if ({Buzz, Snoozing} !== 2'b00 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL stop_snooze buzz=%b snz=%b want 0 0", Buzz, Snoozing);
        end
        AlarmEn = 0;
    endtask

    task automatic test_set_mode();
        do_reset();
        repeat (17) tick();
        for (int i = 0; i < 59; i++) begin
            drive(1, 0, 1, 0, i < 6);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1, 1);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL set_step got=%h want=%h", obs, exp_vec());
            end
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({THrs, TMin, TSec, TDay} !== {7'd3, 7'd2, 7'd17, 3'd2}) begin
            fails++;
            $display("FAIL set_mode got=%0d:%0d:%0d d%0d want=3:2:17 d2",
                     THrs, TMin, TSec, TDay);
        end
    endtask

    task automatic test_disable();
        do_reset();
        AlarmSel = 3;
        for (int i = 0; i < 11; i++) begin
            drive(0, 1, 1, i < 5, 0);
            tick();
        end
        AlarmSel = 2;
        drive(0, 1, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        AlarmEn = 4'b0100;
        for (int i = 0; i < 100 && !Buzz; i++) tick();
        checks++;
        if (Buzz !== 1'b1 || BuzzIdx !== 2'd2) begin
            fails++;
            $display("FAIL ring_idx2 buzz=%b idx=%0d want 1 idx 2", Buzz, BuzzIdx);
        end
        repeat (3) tick();
        AlarmEn = 0;
        tick();
        checks++;
        if (Buzz !== 1'b0 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL disarm buzz=%b want 0", Buzz);
        end
        Alarmset = 1; AlarmSel = 3;
        #1;
        checks++;
        if ({DispHrs, DispMin} !== {7'd5, 7'd11}) begin
            fails++;
            $display("FAIL disp_alarm3 got=%0d:%0d want=5:11", DispHrs, DispMin);
        end
        Alarmset = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            Reset    = ($urandom_range(0, 499) != 0);
            Timeset  = ($urandom_range(0, 19) == 0);
            Alarmset = ($urandom_range(0, 3) == 0);
            Minadv   = ($urandom_range(0, 3) == 0);
            Hrsadv   = ($urandom_range(0, 3) == 0);
            Dayadv   = ($urandom_range(0, 3) == 0);
            AlarmSel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) AlarmEn = 4'($urandom);
            Snooze   = ($urandom_range(0, 29) == 0);
            Stop     = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        Reset = 0;
        drive(0, 0, 0, 0, 0);
        AlarmSel = 0; AlarmEn = 0; Snooze = 0; Stop = 0;
        t = 0; mode = 0; idx = 0; ring_left = 0; snz_left = 0;
        for (int j = 0; j < NA; j++) begin
            al_h[j] = 0;
            al_m[j] = 0;
        end
        test_reset();
        test_rollover();
        test_alarm_ring();
        test_snooze();
        test_set_mode();
        test_disable();
        test_reset_mid_ring();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    task automatic test_reset_mid_ring();
        do_reset();
        AlarmSel = 3;
        drive(0, 1, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        AlarmEn = 4'b1000;
        for (int i = 0; i < 100 && !Buzz; i++) tick();
        repeat (4) tick();
        checks++;
        if (Buzz !== 1'b1 || BuzzIdx !== 2'd3) begin
            fails++;
            $display("FAIL pre_reset buzz=%b idx=%0d want 1 idx 3", Buzz, BuzzIdx);
        end
        AlarmEn = 0;
        Reset = 0;
        tick();
        Reset = 1;
        checks++;
        if ({Buzz, BuzzIdx, TSec, TMin, THrs, TDay} !== 27'd0) begin
            fails++;
            $display("FAIL reset_mid_ring buzz=%b idx=%0d t=%0d:%0d:%0d d%0d want all 0",
                     Buzz, BuzzIdx, THrs, TMin, TSec, TDay);
        end
    endtask

endmodule
